fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory, owns the PC and the IF/ID register,
// absorbs one returned word in a skid buffer under stall, and flushes in-flight fetches on branch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StFlush} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] flush_addr_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc4_q;
    logic        skid_valid_q;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    assign pc_inc         = pc_q + 32'd4;
    assign target_aligned = branch_target & ~32'd3;

    assign imem_req  = (state_q == StFetch) || (state_q == StFlush);
    // In FLUSH the memory still owns the old request, so its address must not move.
    assign imem_addr = (state_q == StFlush) ? flush_addr_q : pc_q;
    assign op_code   = instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            flush_addr_q <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            skid_valid_q <= 1'b0;
            instr        <= '0;
            pc_plus4     <= '0;
            instr_valid  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: state_q <= StFetch;

                StFetch: begin
                    if (branch_taken) begin
                        instr_valid  <= 1'b0;
                        skid_valid_q <= 1'b0;
                        pc_q         <= target_aligned;
                        flush_addr_q <= pc_q;
                        state_q      <= imem_ack ? StFetch : StFlush;
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                        if (!stall || !instr_valid) begin
                            instr       <= imem_rdata;
                            pc_plus4    <= pc_inc;
                            instr_valid <= 1'b1;
                        end else begin
                            // IF/ID is occupied and held: park the word until release.
                            skid_instr_q <= imem_rdata;
                            skid_pc4_q   <= pc_inc;
                            skid_valid_q <= 1'b1;
                            state_q      <= StHold;
                        end
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end

                StHold: begin
                    if (branch_taken) begin
                        instr_valid  <= 1'b0;
                        skid_valid_q <= 1'b0;
                        pc_q         <= target_aligned;
                        state_q      <= StFetch;
                    end else if (!stall) begin
                        instr        <= skid_instr_q;
                        pc_plus4     <= skid_pc4_q;
                        instr_valid  <= skid_valid_q;
                        skid_valid_q <= 1'b0;
                        state_q      <= StFetch;
                    end
                end

                StFlush: begin
                    if (branch_taken) begin
                        pc_q <= target_aligned;
                    end
                    if (imem_ack) begin
                        state_q <= StFetch;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, and random
// stimulus compared against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [31:0] w_pc4;
    logic        w_valid;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .instr(instr),
        .op_code(op_code), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .instr(w_instr),
        .op_code(w_op), .pc_plus4(w_pc4), .instr_valid(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a PC, an IF/ID record, at most one parked word, and at most one
    // abandoned request whose reply must be swallowed.
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc4;
    } parked_t;

    logic        m_idle;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    parked_t     m_parked[$];
    logic        m_pend;
    logic [31:0] m_paddr;

    function automatic logic m_req();
        return !m_idle && (m_parked.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_pend ? m_paddr : m_pc;
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_parked.delete();
        m_pend  = 1'b0;
        m_paddr = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        parked_t     p;
        tgt = {branch_target[31:2], 2'b00};
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_parked.size() != 0) begin
            if (branch_taken) begin
                m_valid = 1'b0;
                m_parked.delete();
                m_pc = tgt;
            end else if (!stall) begin
                p = m_parked.pop_front();
                m_instr = p.word;
                m_pc4   = p.pc4;
                m_valid = 1'b1;
            end
        end else if (m_pend) begin
            if (branch_taken) m_pc = tgt;
            if (imem_ack) m_pend = 1'b0;
        end else begin
            if (branch_taken) begin
                m_valid = 1'b0;
                if (!imem_ack) begin
                    m_pend  = 1'b1;
                    m_paddr = m_pc;
                end
                m_pc = tgt;
            end else if (imem_ack) begin
                if (!stall || !m_valid) begin
                    m_instr = imem_rdata;
                    m_pc4   = m_pc + 32'd4;
                    m_valid = 1'b1;
                end else begin
                    p.word = imem_rdata;
                    p.pc4  = m_pc + 32'd4;
                    m_parked.push_back(p);
                end
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, m_req()});
        if (m_req()) chk({tag, "_addr"}, imem_addr, m_addr());
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_op"}, {26'b0, op_code}, {26'b0, m_instr[31:26]});
        chk({tag, "_pc4"}, pc_plus4, m_pc4);
        chk({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
    endtask

    // Apply one cycle of inputs (called at a falling edge), return at the next falling edge.
    task automatic drive(input logic a, input logic [31:0] d, input logic s, input logic b,
                         input logic [31:0] t);
        imem_ack      = a;
        imem_rdata    = d;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [5:0]  e_op;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 6'd0,  32'h00};
        tbl[1] = '{1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 6'd35, 32'h04};
        tbl[2] = '{1'b1, 32'hAC01_0004, 1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 6'd43, 32'h08};
        tbl[3] = '{1'b1, 32'h1022_0003, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 6'd4,  32'h0C};
        tbl[4] = '{1'b1, 32'h0022_0020, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 6'd0,  32'h10};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 6'd0,  32'h10};
        tbl[6] = '{1'b1, 32'h2001_0005, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 6'd8,  32'h14};
        tbl[7] = '{1'b1, 32'h8C00_0000, 1'b0, 1'b1, 32'h43, 1'b1, 32'h40, 1'b0, 6'd8,  32'h14};
        tbl[8] = '{1'b1, 32'hAC00_0000, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 6'd43, 32'h44};

        rst_n = 1'b0;
        do_reset();

        // Reset values before the first edge after release.
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_op",    {26'b0, op_code},     32'h0);
        chk("rst_pc4",   pc_plus4,             32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk($sformatf("tbl%0d_req", i),   {31'b0, imem_req},    {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  imem_addr,            tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_op", i),    {26'b0, op_code},     {26'b0, tbl[i].e_op});
            chk($sformatf("tbl%0d_pc4", i),   pc_plus4,             tbl[i].e_pc4);
        end

        // Stall with a returning ack: word parks, memory idles, then it drains in order.
        drive(1'b1, 32'h1000_0001, 1'b1, 1'b0, 32'h0);
        chk("hold1_req",   {31'b0, imem_req}, 32'h0);
        chk("hold1_instr", instr,             32'hAC00_0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("hold2_req",   {31'b0, imem_req}, 32'h0);
        chk("hold2_instr", instr,             32'hAC00_0000);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rel_instr",   instr,                32'h1000_0001);
        chk("rel_valid",   {31'b0, instr_valid}, 32'h1);
        chk("rel_pc4",     pc_plus4,             32'h48);
        chk("rel_req",     {31'b0, imem_req},    32'h1);
        chk("rel_addr",    imem_addr,            32'h48);

        // Branch and stall together in HOLD: parked word dropped, redirect wins.
        drive(1'b1, 32'h2000_0002, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h83);
        chk("hbr_valid", {31'b0, instr_valid}, 32'h0);
        chk("hbr_req",   {31'b0, imem_req},    32'h1);
        chk("hbr_addr",  imem_addr,            32'h80);
        drive(1'b1, 32'h8C00_0003, 1'b0, 1'b0, 32'h0);
        chk("hbr_instr", instr,    32'h8C00_0003);
        chk("hbr_pc4",   pc_plus4, 32'h84);

        // Branch while the request at 0x10 is outstanding, ack two cycles later.
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'hAC01_0004, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h1022_0003, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h0022_0020, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        chk("fl1_addr",  imem_addr,            32'h10);
        chk("fl1_valid", {31'b0, instr_valid}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("fl2_addr",  imem_addr,            32'h10);
        chk("fl2_valid", {31'b0, instr_valid}, 32'h0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("fl3_addr",  imem_addr,            32'h40);
        chk("fl3_valid", {31'b0, instr_valid}, 32'h0);
        chk("fl3_instr", instr,                32'h0022_0020);
        drive(1'b1, 32'hAC00_1111, 1'b0, 1'b0, 32'h0);
        chk("fl4_instr", instr,    32'hAC00_1111);
        chk("fl4_pc4",   pc_plus4, 32'h44);

        // Wrap of the fetch address past 2^32 on the second instance.
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h0400_0000, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc4",   w_pc4,  32'h0);
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_valid", {31'b0, w_valid}, 32'h1);

        // Short asynchronous reset pulse while flushing.
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h8C00_00AA, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        chk("arst_pre_addr", imem_addr, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'b0, imem_req},    32'h0);
        chk("arst_instr", instr,                32'h0);
        chk("arst_op",    {26'b0, op_code},     32'h0);
        chk("arst_pc4",   pc_plus4,             32'h0);
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("arst_req1",  {31'b0, imem_req}, 32'h1);
        chk("arst_addr1", imem_addr,         32'h0);

        // Random traffic against the model.
        do_reset();
        cmp_model("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            logic a;
            a = m_req() && ($urandom_range(0, 9) < 6);
            drive(a, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0),
                  $urandom);
            cmp_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
